result_disp: RTL and testbench

RESULT_DISP -- requirements
Module: result_disp

---
 rtl/result_disp.sv | 168 ++++++++++++++++
 tb/tb_result_disp.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/result_disp.sv
// Signed calculator result to four-digit multiplexed 7-segment display.
// A conversion FSM (abs value + double-dabble) updates the digit registers
// atomically, while a free-running scan drives the digits one at a time.
module result_disp #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] data_in,
  input  logic        err,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        busy
);

  localparam int unsigned CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SHIFT_N = 11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ABS   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [6:0] G_MINUS = 7'b0111111;
  localparam logic [6:0] G_E     = 7'b0000110;
  localparam logic [6:0] G_R     = 7'b0101111;
  localparam logic [6:0] G_ZERO  = 7'b1000000;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = G_BLANK;
    endcase
  endfunction

  logic [1:0]       state_q, state_d;
  logic [11:0]      shadow_q, shadow_d;
  logic             sign_q, sign_d;
  logic [11:0]      mag_q, mag_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] refresh_q, refresh_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       dig_q [4];
  logic [6:0]       dig_d [4];
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             busy_q, busy_d;

  logic [15:0]      bcd_adj;
  logic [11:0]      sext;

  // Next-state logic for conversion FSM, scan counter and registered outputs.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    refresh_d = refresh_q;
    idx_d     = idx_q;
    for (int i = 0; i < 4; i++) dig_d[i] = dig_q[i];
    bcd_adj   = bcd_q;
    sext      = {shadow_q[10], shadow_q[10:0]};

    for (int i = 0; i < 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end

    case (state_q)
      S_IDLE: begin
        if ({err, data_in} != shadow_q) begin
          shadow_d = {err, data_in};
          state_d  = S_ABS;
        end
      end
      S_ABS: begin
        sign_d  = shadow_q[10];
        mag_d   = shadow_q[10] ? 12'(~sext + 12'd1) : sext;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // Magnitude never exceeds 1024, so bit 10 is the top bit fed in.
        bcd_d = {bcd_adj[14:0], mag_q[10]};
        mag_d = {mag_q[10:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(SHIFT_N - 1)) state_d = S_LATCH;
      end
      default: begin
        if (shadow_q[11] || (bcd_q[15:12] != 4'd0)) begin
          dig_d[3] = G_BLANK;
          dig_d[2] = G_E;
          dig_d[1] = G_R;
          dig_d[0] = G_R;
        end else begin
          dig_d[3] = sign_q ? G_MINUS : G_BLANK;
          dig_d[2] = (bcd_q[11:8] == 4'd0) ? G_BLANK : glyph(bcd_q[11:8]);
          dig_d[1] = (bcd_q[11:4] == 8'd0) ? G_BLANK : glyph(bcd_q[7:4]);
          dig_d[0] = glyph(bcd_q[3:0]);
        end
        state_d = S_IDLE;
      end
    endcase

    if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      idx_d     = idx_q + 2'd1;
    end else begin
      refresh_d = refresh_q + CNT_W'(1);
    end

    seg_d  = dig_d[idx_d];
    an_d   = ~(4'b0001 << idx_d);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any conversion and shows "   0".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      refresh_q <= '0;
      idx_q     <= '0;
      dig_q[3]  <= G_BLANK;
      dig_q[2]  <= G_BLANK;
      dig_q[1]  <= G_BLANK;
      dig_q[0]  <= G_ZERO;
      seg_q     <= G_ZERO;
      an_q      <= 4'b1110;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      for (int i = 0; i < 4; i++) dig_q[i] <= dig_d[i];
      seg_q     <= seg_d;
      an_q      <= an_d;
      busy_q    <= busy_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_result_disp.sv
// Directed bench for result_disp with a fast scan (REFRESH_DIV = 4).
module tb_result_disp;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] data_in;
  logic        err;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GR = 7'b0101111;
  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G9 = 7'b0010000;

  result_disp #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .err     (err),
    .seg     (seg),
    .an      (an),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Watch a full scan cycle and compare the glyph shown for each digit.
  task automatic check_disp(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] got [4];
    for (int i = 0; i < 4; i++) got[i] = 7'bx;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      case (an)
        4'b1110: got[0] = seg;
        4'b1101: got[1] = seg;
        4'b1011: got[2] = seg;
        4'b0111: got[3] = seg;
        default: ;
      endcase
    end
    chk({tag, ".d3"}, 32'(got[3]), 32'(e3));
    chk({tag, ".d2"}, 32'(got[2]), 32'(e2));
    chk({tag, ".d1"}, 32'(got[1]), 32'(e1));
    chk({tag, ".d0"}, 32'(got[0]), 32'(e0));
  endtask

  // Apply a value at a falling edge and count cycles busy stays high.
  task automatic run_conv(input logic [10:0] d, input logic e, output int n);
    data_in = d;
    err     = e;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
  endtask

  initial begin
    int n;
    int n2;
    rst     = 1'b1;
    data_in = 11'd0;
    err     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.an", 32'(an), 32'(4'b1110));
    chk("rst.seg", 32'(seg), 32'(G0));
    chk("rst.busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Scan order with idle input: index advances every 4 cycles.
    @(negedge clk);
    chk("scan0", 32'(an), 32'(4'b1110));
    repeat (4) @(negedge clk);
    chk("scan1", 32'(an), 32'(4'b1101));
    repeat (4) @(negedge clk);
    chk("scan2", 32'(an), 32'(4'b1011));
    repeat (4) @(negedge clk);
    chk("scan3", 32'(an), 32'(4'b0111));
    chk("idle.busy", 32'(busy), 32'd0);
    check_disp("zero", BL, BL, BL, G0);

    run_conv(11'd123, 1'b0, n);
    chk("p123.busy", 32'(n), 32'd13);
    check_disp("p123", BL, G1, G2, G3);

    run_conv(11'h7F9, 1'b0, n);
    chk("m7.busy", 32'(n), 32'd13);
    check_disp("m7", MI, BL, BL, G7);

    run_conv(11'd10, 1'b0, n);
    check_disp("p10", BL, BL, G1, G0);

    run_conv(11'h419, 1'b0, n);   // -999
    check_disp("m999", MI, G9, G9, G9);

    run_conv(11'h400, 1'b0, n);   // -1024
    chk("m1024.busy", 32'(n), 32'd13);
    check_disp("m1024", BL, GE, GR, GR);

    run_conv(11'd0, 1'b0, n);
    check_disp("back0", BL, BL, BL, G0);

    run_conv(11'd0, 1'b1, n);
    chk("err.busy", 32'(n), 32'd13);
    check_disp("err", BL, GE, GR, GR);

    // Input changes mid-conversion: first value finishes, then the new one runs.
    err     = 1'b0;
    data_in = 11'd5;
    repeat (3) @(negedge clk);
    data_in = 11'd905;
    n = 3;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    chk("chg.busy1", 32'(n), 32'd13);
    chk("chg.gap", 32'(busy), 32'd0);
    run_conv(11'd905, 1'b0, n2);
    chk("chg.busy2", 32'(n2), 32'd13);
    check_disp("p905", BL, G9, G0, G5);

    // Reset during SHIFT iteration 6 aborts and a fresh conversion follows.
    data_in = 11'd500;
    repeat (7) @(negedge clk);
    chk("abort.pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.an", 32'(an), 32'(4'b1110));
    chk("abort.seg", 32'(seg), 32'(G0));
    @(negedge clk);
    rst = 1'b0;
    run_conv(11'd500, 1'b0, n);
    chk("abort.busy2", 32'(n), 32'd13);
    check_disp("p500", BL, G5, G0, G0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
